// File: rtl/out_stream_controller.sv
// rtl/out_stream_controller.sv - CPU output port to valid/ready stream bridge with FIFO, stall and run counting
module out_stream_controller #(
    parameter int WIDTH       = 36,
    parameter int DEPTH       = 8,
    parameter int ADDRW       = 3,
    parameter int COUNTWIDTH  = 16,
    parameter int STALLMARGIN = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [COUNTWIDTH-1:0] expected,
    input  logic                  outFlag,
    input  logic [WIDTH-1:0]      out,
    output logic                  cpuStall,
    output logic                  outValid,
    output logic [WIDTH-1:0]      outData,
    input  logic                  outReady,
    output logic [COUNTWIDTH-1:0] wordCount,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDRW:0] FULL      = (ADDRW+1)'(DEPTH);
    localparam logic [ADDRW:0] STALL_LVL = (ADDRW+1)'(DEPTH - STALLMARGIN);

    state_t                  state;
    logic [WIDTH-1:0]        mem [DEPTH];
    logic [ADDRW-1:0]        wr_ptr;
    logic [ADDRW-1:0]        rd_ptr;
    logic [ADDRW:0]          occ;
    logic [ADDRW:0]          occ_next;
    logic [COUNTWIDTH-1:0]   exp_q;
    logic [COUNTWIDTH-1:0]   wc_inc;
    logic                    push_try;
    logic                    push_ok;
    logic                    pop;

    assign outValid = (occ != '0);
    assign outData  = outValid ? mem[rd_ptr] : '0;
    assign pop      = outValid && outReady;
    assign push_try = (state == RUN) && outFlag;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign push_ok  = push_try && ((occ != FULL) || pop);
    assign wc_inc   = (wordCount == '1) ? wordCount : wordCount + COUNTWIDTH'(1);
    assign cpuStall = (state == RUN) && (occ >= STALL_LVL);
    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == DONE);

    always_comb begin
        occ_next = occ;
        if (push_ok && !pop) begin
            occ_next = occ + (ADDRW+1)'(1);
        end else if (pop && !push_ok) begin
            occ_next = occ - (ADDRW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= out;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            wordCount <= '0;
            overflow  <= 1'b0;
            exp_q     <= '0;
        end else begin
            occ <= occ_next;
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDRW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDRW'(1);
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        exp_q     <= expected;
                        wordCount <= '0;
                        overflow  <= 1'b0;
                        state     <= (expected == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (push_ok) begin
                        wordCount <= wc_inc;
                        if (wc_inc == exp_q) begin
                            state <= DRAIN;
                        end
                    end else if (push_try) begin
                        overflow <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (occ_next == '0) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_out_stream_controller.sv
// tb/tb_out_stream_controller.sv - scoreboard bench for out_stream_controller
module tb_out_stream_controller;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] expected;
    logic        outFlag;
    logic [35:0] out;
    logic        cpuStall;
    logic        outValid;
    logic [35:0] outData;
    logic        outReady;
    logic [15:0] wordCount;
    logic        busy;
    logic        done;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;
    logic [35:0] sb[$];

    out_stream_controller dut (
        .clock(clock), .reset(reset), .start(start), .expected(expected),
        .outFlag(outFlag), .out(out), .cpuStall(cpuStall), .outValid(outValid),
        .outData(outData), .outReady(outReady), .wordCount(wordCount),
        .busy(busy), .done(done), .overflow(overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Outputs sampled mid-cycle; popped words checked against the scoreboard head.
    task automatic tick();
        @(negedge clock);
        if (outValid && outReady) begin
            if (sb.size() == 0) chk("unexpected_pop", 1, 0);
            else chk("pop_data", outData, sb.pop_front());
        end
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [35:0] w, input bit accept);
        outFlag = 1'b1;
        out     = w;
        if (accept) sb.push_back(w);
        tick();
        outFlag = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int c = 0;
        outFlag  = 1'b0;
        outReady = 1'b1;
        while (sb.size() != 0 && c < max_cycles) begin
            tick();
            c++;
        end
        chk("drain_left", sb.size(), 0);
    endtask

    task automatic do_start(input logic [15:0] e);
        start    = 1'b1;
        expected = e;
        tick();
        start    = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; expected = '0; outFlag = 1'b0; out = '0; outReady = 1'b0;
        #12;
        chk("rst_stall", cpuStall, 0);
        chk("rst_valid", outValid, 0);
        chk("rst_data", outData, 0);
        chk("rst_wc", wordCount, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        reset = 1'b1;
        @(posedge clock); #1;

        push(36'h111, 1'b0);
        chk("idle_push_ignored", outValid, 0);

        // Basic run; a push in the start cycle is ignored
        outReady = 1'b1;
        start = 1'b1; expected = 16'd3; outFlag = 1'b1; out = 36'hDEAD;
        tick();
        start = 1'b0; outFlag = 1'b0;
        chk("basic_busy", busy, 1);
        chk("basic_wc0", wordCount, 0);
        push(36'h1, 1'b1);
        chk("basic_visible", outData, 36'h1);
        push(36'h2, 1'b1);
        push(36'h3, 1'b1);
        chk("basic_wc", wordCount, 3);
        chk("basic_busy_tail", busy, 1);
        chk("basic_notdone", done, 0);
        drain(10);
        chk("basic_done", done, 1);
        chk("basic_busy_end", busy, 0);

        // Backpressure and stall threshold
        outReady = 1'b0;
        do_start(16'd20);
        for (int i = 1; i <= 5; i++) begin
            push(36'h200 + 36'(i), 1'b1);
            if (i == 4) chk("bp_nostall4", cpuStall, 0);
        end
        chk("bp_stall5", cpuStall, 1);
        outReady = 1'b1;
        tick();
        chk("bp_unstall", cpuStall, 0);
        for (int i = 6; i <= 20; i++) begin
            if (i == 6) begin start = 1'b1; expected = 16'd2; end
            push(36'h200 + 36'(i), 1'b1);
            start = 1'b0;
            if (i == 6) begin
                chk("run_start_ignored_wc", wordCount, 6);
                chk("run_start_ignored_busy", busy, 1);
            end
        end
        outReady = 1'b0;
        push(36'hBAD, 1'b0);
        chk("drain_push_wc", wordCount, 20);
        chk("drain_busy", busy, 1);
        drain(20);
        chk("bp_done", done, 1);
        chk("bp_valid_end", outValid, 0);

        // Overflow, full plus simultaneous pop, pointer laps
        outReady = 1'b0;
        do_start(16'd40);
        for (int i = 0; i < 8; i++) push(36'hA_0000_0000 + 36'(i), 1'b1);
        chk("full_ovf_clear", overflow, 0);
        push(36'hF00D, 1'b0);
        chk("ovf_set", overflow, 1);
        chk("ovf_wc", wordCount, 8);
        outReady = 1'b1;
        for (int i = 8; i < 33; i++) push(36'hA_0000_0000 + 36'(i), 1'b1);
        chk("fullpop_wc", wordCount, 33);
        chk("fullpop_still_full", cpuStall, 1);
        chk("ovf_sticky", overflow, 1);
        drain(20);
        chk("laps_busy", busy, 1);
        chk("laps_empty", outValid, 0);
        for (int i = 33; i < 40; i++) push(36'hA_0000_0000 + 36'(i), 1'b1);
        drain(20);
        chk("laps_done", done, 1);
        chk("laps_wc", wordCount, 40);
        chk("ovf_kept", overflow, 1);

        // Zero-length run
        do_start(16'd0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_ovf_cleared", overflow, 0);
        chk("zero_wc", wordCount, 0);
        push(36'h123, 1'b0);
        chk("done_push_ignored", outValid, 0);

        // Reset mid-run discards buffered words
        outReady = 1'b0;
        do_start(16'd10);
        for (int i = 0; i < 4; i++) push(36'h300 + 36'(i), 1'b0);
        chk("pre_rst_valid", outValid, 1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_valid", outValid, 0);
        chk("midrst_wc", wordCount, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_data", outData, 0);
        chk("midrst_stall", cpuStall, 0);
        reset = 1'b1;
        outReady = 1'b1;
        do_start(16'd2);
        push(36'h77, 1'b1);
        push(36'h78, 1'b1);
        drain(10);
        chk("post_rst_done", done, 1);
        chk("post_rst_wc", wordCount, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
